// File: rtl/dosificador_caudal.sv
// Dose controller: opens the valve and counts a packed-BCD target down on each flow pulse.
// Latency: start to valve open is 1 cycle; flow_pulse rise to remaining_ml update is SYNC_STAGES+1 cycles.
// Backpressure: none; start is ignored unless IDLE, pulses are ignored outside DISPENSE.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start, abort, clear  level controls from the keypad/display logic
//   target_ml[15:0]      packed BCD target volume, sampled on the start cycle only
//   flow_pulse           raw asynchronous flow-sensor pulse
//   valve_open           registered valve drive
//   busy, done, fault    status (done is a one-cycle pulse)
//   fault_code[1:0]      00 none, 01 invalid BCD target, 10 flow timeout
//   remaining_ml[15:0]   packed BCD volume still to dispense
//   total_ml[15:0]       packed BCD dispensed-volume totalizer (only with DOSE_TOTALIZER_EN)
// Optional feature macro: DOSE_TOTALIZER_EN
module dosificador_caudal #(
  parameter int ML_PER_PULSE   = 6,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        clear,
  input  logic [15:0] target_ml,
  input  logic        flow_pulse,
  output logic        valve_open,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] remaining_ml
`ifdef DOSE_TOTALIZER_EN
  ,
  output logic [15:0] total_ml
`endif
);

  localparam int          TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  STEP      = 4'(ML_PER_PULSE);

  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE, S_FAULT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse;
  logic                   last_pulse;
  logic [15:0]            remaining_q, remaining_d;
  logic [1:0]             fault_code_q, fault_code_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   valve_q, done_q, done_d;

  function automatic logic bcd_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Digit-wise subtract of a single BCD digit with borrow rippling upward.
  function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [3:0] b);
    logic [15:0] r;
    logic [4:0]  d;
    logic        brw;
    r   = '0;
    brw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} - {1'b0, (i == 0) ? b : 4'd0} - {4'd0, brw};
      if (d[4]) begin
        r[i*4 +: 4] = 4'(d + 5'd10);
        brw         = 1'b1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        brw         = 1'b0;
      end
    end
    return r;
  endfunction

  // Rising edge after the synchronizer; one edge is one sensor pulse.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

  // remaining <= STEP only when the upper three digits are zero.
  assign last_pulse = (remaining_q[15:4] == 12'h000) && (remaining_q[3:0] <= STEP);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    fault_code_d = fault_code_q;
    tmo_d        = tmo_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!bcd_ok(target_ml)) begin
            state_d      = S_FAULT;
            fault_code_d = 2'b01;
          end else if (target_ml == 16'h0000) begin
            done_d = 1'b1;
          end else begin
            remaining_d = target_ml;
            state_d     = S_DISPENSE;
            tmo_d       = '0;
          end
        end
      end
      S_DISPENSE: begin
        // abort outranks a coincident pulse, which is then discarded
        if (abort) begin
          state_d = S_IDLE;
        end else if (pulse) begin
          tmo_d = '0;
          if (last_pulse) begin
            remaining_d = 16'h0000;
            state_d     = S_DONE;
            done_d      = 1'b1;
          end else begin
            remaining_d = bcd_sub(remaining_q, STEP);
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b10;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (clear) begin
          state_d      = S_IDLE;
          fault_code_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      remaining_q  <= 16'h0000;
      fault_code_q <= 2'b00;
      tmo_q        <= '0;
      valve_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], flow_pulse};
      prev_q       <= sync_q[SYNC_STAGES-1];
      remaining_q  <= remaining_d;
      fault_code_q <= fault_code_d;
      tmo_q        <= tmo_d;
      valve_q      <= (state_d == S_DISPENSE);
      done_q       <= done_d;
    end
  end

  assign valve_open   = valve_q;
  assign busy         = (state_q == S_DISPENSE);
  assign done         = done_q;
  assign fault        = (state_q == S_FAULT);
  assign fault_code   = fault_code_q;
  assign remaining_ml = remaining_q;

`ifdef DOSE_TOTALIZER_EN
  logic [15:0] total_q, total_d;

  // Digit-wise add of a single BCD digit; carry out of the thousands digit wraps.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] b);
    logic [15:0] r;
    logic [4:0]  d;
    logic        cy;
    r  = '0;
    cy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, (i == 0) ? b : 4'd0} + {4'd0, cy};
      if (d > 5'd9) begin
        r[i*4 +: 4] = 4'(d - 5'd10);
        cy          = 1'b1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        cy          = 1'b0;
      end
    end
    return r;
  endfunction

  // On the final pulse only the leftover units digit was actually dispensed.
  always_comb begin
    total_d = total_q;
    if (state_q == S_DISPENSE && !abort && pulse)
      total_d = bcd_add(total_q, last_pulse ? remaining_q[3:0] : STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) total_q <= 16'h0000;
    else     total_q <= total_d;
  end

  assign total_ml = total_q;
`endif

endmodule

// File: tb/tb_dosificador_caudal.sv
module tb_dosificador_caudal;

  logic        clk = 1'b0;
  logic        rst, start, abort, clear, flow_pulse;
  logic [15:0] target_ml;
  logic        valve_open, busy, done, fault;
  logic [1:0]  fault_code;
  logic [15:0] remaining_ml;
`ifdef DOSE_TOTALIZER_EN
  logic [15:0] total_ml;
`endif

  int checks = 0;
  int errors = 0;

  dosificador_caudal #(
    .ML_PER_PULSE  (6),
    .TIMEOUT_CYCLES(100),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .clear       (clear),
    .target_ml   (target_ml),
    .flow_pulse  (flow_pulse),
    .valve_open  (valve_open),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .fault_code  (fault_code),
    .remaining_ml(remaining_ml)
`ifdef DOSE_TOTALIZER_EN
    ,
    .total_ml    (total_ml)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full sensor pulse: 2 cycles high, 2 low; the count updates on the 3rd edge.
  task automatic pulse_full();
    flow_pulse = 1'b1;
    tick(); tick();
    flow_pulse = 1'b0;
    tick(); tick();
  endtask

  task automatic begin_dose(input logic [15:0] t);
    target_ml = t;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; clear = 1'b0;
    flow_pulse = 1'b0; target_ml = 16'h0000;
    tick(); tick();
    chk("rst_valve", {15'd0, valve_open}, 16'd0);
    chk("rst_busy",  {15'd0, busy},       16'd0);
    chk("rst_done",  {15'd0, done},       16'd0);
    chk("rst_fault", {15'd0, fault},      16'd0);
    chk("rst_code",  {14'd0, fault_code}, 16'd0);
    chk("rst_rem",   remaining_ml,        16'h0000);
    rst = 1'b0;
    tick();

    // 20 mL in four pulses of 6
    begin_dose(16'h0020);
    chk("d20_valve", {15'd0, valve_open}, 16'd1);
    chk("d20_busy",  {15'd0, busy},       16'd1);
    chk("d20_rem0",  remaining_ml,        16'h0020);
    pulse_full(); chk("d20_p1", remaining_ml, 16'h0014);
    pulse_full(); chk("d20_p2", remaining_ml, 16'h0008);
    pulse_full(); chk("d20_p3", remaining_ml, 16'h0002);
    flow_pulse = 1'b1; tick(); tick(); flow_pulse = 1'b0; tick();
    chk("d20_p4",      remaining_ml,        16'h0000);
    chk("d20_done",    {15'd0, done},       16'd1);
    chk("d20_vclosed", {15'd0, valve_open}, 16'd0);
    tick();
    chk("d20_done_end", {15'd0, done}, 16'd0);
    chk("d20_idle",     {15'd0, busy}, 16'd0);
    tick();

    // borrow across three digits
    begin_dose(16'h1000);
    pulse_full(); chk("d1000_p1", remaining_ml, 16'h0994);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("d1000_abort_v",   {15'd0, valve_open}, 16'd0);
    chk("d1000_abort_rem", remaining_ml,        16'h0994);
    tick();

    // abort coincident with the 3rd qualified pulse discards it
    begin_dose(16'h0050);
    pulse_full(); chk("d50_p1", remaining_ml, 16'h0044);
    pulse_full(); chk("d50_p2", remaining_ml, 16'h0038);
    flow_pulse = 1'b1; tick(); tick();
    flow_pulse = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk("d50_rem",   remaining_ml,        16'h0038);
    chk("d50_valve", {15'd0, valve_open}, 16'd0);
    chk("d50_done",  {15'd0, done},       16'd0);
    chk("d50_busy",  {15'd0, busy},       16'd0);
    tick();
    chk("d50_done2", {15'd0, done}, 16'd0);
    chk("d50_rem2",  remaining_ml,  16'h0038);

    // flow timeout after 100 cycles with no pulses
    begin_dose(16'h0030);
    repeat (99) tick();
    chk("tmo_early_fault", {15'd0, fault}, 16'd0);
    chk("tmo_early_busy",  {15'd0, busy},  16'd1);
    tick();
    chk("tmo_fault", {15'd0, fault},      16'd1);
    chk("tmo_code",  {14'd0, fault_code}, 16'd2);
    chk("tmo_valve", {15'd0, valve_open}, 16'd0);
    chk("tmo_rem",   remaining_ml,        16'h0030);
    begin_dose(16'h0010);
    chk("tmo_start_ign", {15'd0, fault},      16'd1);
    chk("tmo_start_vlv", {15'd0, valve_open}, 16'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_fault", {15'd0, fault},      16'd0);
    chk("clr_code",  {14'd0, fault_code}, 16'd0);
    chk("clr_rem",   remaining_ml,        16'h0030);

    // invalid BCD target
    begin_dose(16'h00A5);
    chk("bad_fault", {15'd0, fault},      16'd1);
    chk("bad_code",  {14'd0, fault_code}, 16'd1);
    chk("bad_valve", {15'd0, valve_open}, 16'd0);
    tick();
    chk("bad_valve2", {15'd0, valve_open}, 16'd0);
    clear = 1'b1; tick(); clear = 1'b0;

    // zero target: done pulse only
    begin_dose(16'h0000);
    chk("zero_done",  {15'd0, done},       16'd1);
    chk("zero_valve", {15'd0, valve_open}, 16'd0);
    chk("zero_busy",  {15'd0, busy},       16'd0);
    tick();
    chk("zero_done2", {15'd0, done}, 16'd0);

    // reset mid-dose closes the valve on the next edge
    begin_dose(16'h0100);
    chk("mid_open", {15'd0, valve_open}, 16'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valve", {15'd0, valve_open}, 16'd0);
    chk("mid_rst_busy",  {15'd0, busy},       16'd0);
    chk("mid_rst_rem",   remaining_ml,        16'h0000);
    tick();

`ifdef DOSE_TOTALIZER_EN
    chk("tot_rst", total_ml, 16'h0000);
    begin_dose(16'h9996);
    repeat (1666) pulse_full();
    chk("tot_9996",     total_ml,      16'h9996);
    chk("tot_9996_rem", remaining_ml,  16'h0000);
    chk("tot_9996_bsy", {15'd0, busy}, 16'd0);
    begin_dose(16'h0008);
    pulse_full(); chk("tot_wrap1", total_ml, 16'h0002);
    pulse_full(); chk("tot_wrap2", total_ml, 16'h0004);
    begin_dose(16'h0010);
    pulse_full(); chk("tot_10_p1", total_ml, 16'h0010);
    pulse_full(); chk("tot_10_p2", total_ml, 16'h0014);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
